// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch stage.
//   - default address / data widths and the halt opcode
//   - queue depth
//   - fetch state encoding (RUN, HALT)
// Optional feature macro used by fetch_stage: FETCH_STATS_EN.
package fetch_pkg;

   localparam int          ADDR_W_DEF      = 8;
   localparam int          DATA_W_DEF      = 32;
   localparam int          DEPTH           = 2;
   localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;

   typedef logic [0:0] fetch_state_t;
   localparam fetch_state_t ST_RUN  = 1'b0;
   localparam fetch_state_t ST_HALT = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} queue between fetch and decode.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   push_i, push_pc_i,
//   push_instr_i            enqueue one entry
//   pop_i                   dequeue the head (only asserted when count_o != 0)
//   flush_i                 drop all entries; wins over push/pop
//   count_o                 number of valid entries (0..2)
//   head_pc_o, head_instr_o head entry; holds the last head value when empty
// The head lives in a dedicated register pair so the outputs keep showing the
// last head after the queue drains, instead of exposing a stale slot.
import fetch_pkg::*;

module fetch_fifo #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic [DATA_W-1:0] push_instr_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [1:0]        count_o,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [DATA_W-1:0] head_instr_o
);

   logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
   logic [DATA_W-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      tail_pc_d    = tail_pc_q;
      tail_instr_d = tail_instr_q;
      count_d      = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_pc_d    = push_pc_i;
                  head_instr_d = push_instr_i;
               end else begin
                  tail_pc_d    = push_pc_i;
                  tail_instr_d = push_instr_i;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  head_pc_d    = tail_pc_q;
                  head_instr_d = tail_instr_q;
               end
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Count stays the same; the new word lands behind whatever
               // remains after the head leaves.
               if (count_q == 2'd2) begin
                  head_pc_d    = tail_pc_q;
                  head_instr_d = tail_instr_q;
                  tail_pc_d    = push_pc_i;
                  tail_instr_d = push_instr_i;
               end else begin
                  head_pc_d    = push_pc_i;
                  head_instr_d = push_instr_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_pc_q    <= '0;
         head_instr_q <= '0;
         tail_pc_q    <= '0;
         tail_instr_q <= '0;
         count_q      <= 2'd0;
      end else begin
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         tail_pc_q    <= tail_pc_d;
         tail_instr_q <= tail_instr_d;
         count_q      <= count_d;
      end
   end

   assign count_o      = count_q;
   assign head_pc_o    = head_pc_q;
   assign head_instr_o = head_instr_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with word-indexed PC, 2-entry output queue,
// taken-branch redirect and halt-opcode stop.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_addr / imem_data combinational instruction memory (same-cycle data)
//   out_valid / out_ready decode handshake; out_instr, out_pc, out_pc_next
//   redirect, redirect_pc taken branch: flush the queue and restart at target
//   halted                state machine is in HALT
//   fetch_count, flush_count  (only with FETCH_STATS_EN) saturating counters
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and the head
// stays stable until it transfers or a redirect flushes it.
import fetch_pkg::*;

module fetch_stage #(
   parameter int          ADDR_W      = ADDR_W_DEF,
   parameter int          DATA_W      = DATA_W_DEF,
   parameter logic [7:0]  RESET_PC    = 8'h00,
   parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pc_next,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]       fetch_count,
   output logic [15:0]       flush_count
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        count;
   logic              pop, push, is_halt;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   // A pop frees a slot in the same cycle, so a full queue still streams.
   assign push      = (state_q == ST_RUN) && !redirect && ((count < 2'd2) || pop);
   assign is_halt   = (imem_data[DATA_W-1 -: 6] == HALT_OPCODE);

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         state_d = ST_RUN;
      end else if (push) begin
         // The halt word is enqueued, but the PC parks on it.
         if (is_halt) state_d = ST_HALT;
         else         pc_d    = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= ADDR_W'(RESET_PC);
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   fetch_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
      .clk_i        (clk),
      .reset_i      (reset),
      .push_i       (push),
      .push_pc_i    (pc_q),
      .push_instr_i (imem_data),
      .pop_i        (pop),
      .flush_i      (redirect),
      .count_o      (count),
      .head_pc_o    (out_pc),
      .head_instr_o (out_instr)
   );

   assign imem_addr   = pc_q;
   assign out_pc_next = out_pc + ADDR_W'(1);
   assign halted      = (state_q == ST_HALT);

`ifdef FETCH_STATS_EN
   logic [15:0] fetch_cnt_q, flush_cnt_q;
   logic        discard;

   // An entry popped in the redirect cycle was accepted, not discarded.
   assign discard = redirect && ((count == 2'd2) || ((count == 2'd1) && !pop));

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         if (push && (fetch_cnt_q != 16'hFFFF))    fetch_cnt_q <= fetch_cnt_q + 16'd1;
         if (discard && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic [7:0]  out_pc_next;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halted;
`ifdef FETCH_STATS_EN
   logic [15:0] fetch_count;
   logic [15:0] flush_count;
`endif

   logic [31:0] mem [256];
   assign imem_data = mem[imem_addr];

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pc_next (out_pc_next),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count (fetch_count),
      .flush_count (flush_count)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard: {pc, instr} in delivery order
   logic [39:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int delivered = 0;

   typedef struct {
      logic       ready;
      logic       redir;
      logic [7:0] rpc;
      logic       exp_valid;
      logic [7:0] exp_pc;
      logic [7:0] exp_addr;
   } row_t;
   row_t tbl[6];

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc);
      exp_q.push_back({pc, mem[pc]});
   endtask

   // Called at a negedge: drives inputs, scores a handshake due at the next
   // rising edge, and returns at the following negedge.
   task automatic cycle(input logic rdy, input logic redir, input logic [7:0] rpc);
      logic [39:0] e;
      out_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      #1;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver: got unexpected pc %0h want nothing", out_pc);
         end else begin
            e = exp_q.pop_front();
            chk("deliver", {out_pc, out_instr}, e);
            delivered++;
         end
      end
      if (redir) exp_q.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      exp_q.delete();
      delivered = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | i;
      reset = 1'b1;
      out_ready = 1'b0;
      redirect = 1'b0;
      redirect_pc = 8'h00;

      tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h02};
      tbl[2] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 8'h41};
      tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 8'h42};
      tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 8'h43};

      @(negedge clk);

      // reset values
      do_reset();
      chk("rst_valid", 40'(out_valid), 40'd0);
      chk("rst_instr", 40'(out_instr), 40'd0);
      chk("rst_pc", 40'(out_pc), 40'd0);
      chk("rst_pc_next", 40'(out_pc_next), 40'd1);
      chk("rst_addr", 40'(imem_addr), 40'd0);
      chk("rst_halted", 40'(halted), 40'd0);
`ifdef FETCH_STATS_EN
      chk("rst_fetch_count", 40'(fetch_count), 40'd0);
      chk("rst_flush_count", 40'(flush_count), 40'd0);
`endif

      // steady stream, one per cycle
      for (int i = 0; i < 16; i++) push_exp(8'(i));
      cycle(1'b1, 1'b0, 8'h00);
      chk("first_valid", 40'(out_valid), 40'd1);
      chk("first_pc", 40'(out_pc), 40'd0);
      chk("first_addr", 40'(imem_addr), 40'd1);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'h00);
      chk("stream_count", 40'(delivered), 40'd9);
      chk("stream_head", 40'(out_pc), 40'd9);

      // reset mid-operation, then backpressure
      do_reset();
      chk("midrst_valid", 40'(out_valid), 40'd0);
      chk("midrst_addr", 40'(imem_addr), 40'd0);
      for (int i = 0; i < 16; i++) push_exp(8'(i));
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      chk("bp_addr2", 40'(imem_addr), 40'd2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
      chk("bp_addr_hold", 40'(imem_addr), 40'd2);
      chk("bp_head", 40'(out_pc), 40'd0);
      chk("bp_valid", 40'(out_valid), 40'd1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00);
      chk("bp_delivered", 40'(delivered), 40'd6);
      chk("bp_next_head", 40'(out_pc), 40'd6);

      // redirect with two queued entries (table-driven)
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
         if (tbl[i].redir) for (int k = 0; k < 8; k++) push_exp(tbl[i].rpc + 8'(k));
         chk($sformatf("tbl%0d_valid", i), 40'(out_valid), 40'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_pc", i), 40'(out_pc), 40'(tbl[i].exp_pc));
         chk($sformatf("tbl%0d_addr", i), 40'(imem_addr), 40'(tbl[i].exp_addr));
`ifdef FETCH_STATS_EN
         if (i == 2) begin
            chk("tbl_flush_count", 40'(flush_count), 40'd1);
            chk("tbl_fetch_count", 40'(fetch_count), 40'd2);
         end
`endif
      end
      chk("tbl_delivered", 40'(delivered), 40'd2);

      // address wrap FE, FF, 00, 01
      do_reset();
      cycle(1'b1, 1'b1, 8'hFE);
      chk("wrap_bubble", 40'(out_valid), 40'd0);
      chk("wrap_addr", 40'(imem_addr), 40'hFE);
      push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_pc_fe", 40'(out_pc), 40'hFE);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_pc_ff", 40'(out_pc), 40'hFF);
      chk("wrap_pc_next", 40'(out_pc_next), 40'h00);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      chk("wrap_pc_01", 40'(out_pc), 40'h01);
      chk("wrap_delivered", 40'(delivered), 40'd3);

      // halt opcode at pc 5, then resume by redirect
      do_reset();
      mem[5] = {6'h3F, 26'd5};
      for (int i = 0; i < 6; i++) push_exp(8'(i));
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00);
      chk("halt_not_yet", 40'(halted), 40'd0);
      cycle(1'b1, 1'b0, 8'h00);
      chk("halt_rise", 40'(halted), 40'd1);
      chk("halt_head", 40'({out_pc, out_instr}), {8'h05, 6'h3F, 26'd5});
      chk("halt_addr", 40'(imem_addr), 40'd5);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
      chk("halt_drained", 40'(out_valid), 40'd0);
      chk("halt_stays", 40'(halted), 40'd1);
      chk("halt_addr_hold", 40'(imem_addr), 40'd5);
      chk("halt_all_seen", 40'(exp_q.size()), 40'd0);
      chk("halt_delivered", 40'(delivered), 40'd6);
      cycle(1'b1, 1'b1, 8'h00);
      chk("resume_halted", 40'(halted), 40'd0);
      chk("resume_addr", 40'(imem_addr), 40'd0);
      push_exp(8'h00); push_exp(8'h01);
      cycle(1'b1, 1'b0, 8'h00);
      chk("resume_valid", 40'(out_valid), 40'd1);
      chk("resume_pc", 40'(out_pc), 40'd0);
      mem[5] = 32'h2000_0005;

      // redirect and pop in the same cycle at count 1
      do_reset();
      push_exp(8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 8'h20);
      chk("rp_pop_taken", 40'(delivered), 40'd1);
      chk("rp_empty", 40'(out_valid), 40'd0);
      chk("rp_hold_head", 40'(out_pc), 40'd0);
`ifdef FETCH_STATS_EN
      chk("rp_no_flush_count", 40'(flush_count), 40'd0);
`endif
      push_exp(8'h20); push_exp(8'h21); push_exp(8'h22);
      cycle(1'b1, 1'b0, 8'h00);
      chk("rp_target", 40'(out_pc), 40'h20);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      chk("rp_delivered", 40'(delivered), 40'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the decode/control path. It owns the word-indexed program counter, drives the address into the combinational instruction memory, and buffers fetched words in a 2-entry queue. It hands instructions to decode over a valid/ready handshake. It accepts taken-branch redirects from the branch-resolution logic (pc+1+imm, eq/ne & zero) and stops fetching on a halt opcode.

## Interface
- ADDR_W, 8: PC / instruction-memory address width (word index, increments by 1).
- DATA_W, 32: instruction width.
- RESET_PC, 8'h00: PC loaded on reset.
- HALT_OPCODE, 6'h3F: opcode (instr[31:26]) that stops fetching.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  ADDR_W  address to instruction memory; equals internal fetch_pc.
- imem_data  in  DATA_W  instruction word for imem_addr, same cycle.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  address of head instruction.
- out_pc_next  out  ADDR_W  out_pc+1, mod 2^ADDR_W, for the branch adder.
- redirect  in  1  taken branch; flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- halted  out  1  state is HALT.

## Operation
- States: RUN, HALT. Reset -> RUN.
- Fetch condition: state RUN, no redirect, and (count<2 or pop this cycle). Fetch pushes {fetch_pc, imem_data} and advances fetch_pc by 1. 8'hFF wraps to 8'h00.
- Pop occurs when out_valid && out_ready. Head advances. Entries are in FIFO order.
- Simultaneous push+pop: count unchanged. This is legal at count 1 and count 2.
- Redirect has priority over everything:
  - count <= 0, fetch_pc <= redirect_pc, state <= RUN.
  - No push that cycle.
  - A pop in the same cycle still counts as accepted by decode.
  - Redirect while HALT resumes fetching.
- Halt: a pushed word whose opcode == HALT_OPCODE is still enqueued (decode sees it). State becomes HALT on that edge, and fetch_pc stops advancing past it. In HALT there are no pushes; the queue continues to drain normally.
- out_valid = (count!=0). out_instr/out_pc show the head entry. When the queue is empty they hold the last head value.
- Reset values: out_valid 0, out_instr 0, out_pc 0, out_pc_next 1, imem_addr RESET_PC, halted 0, all entries 0.
- Reset mid-operation discards queue contents and any pending redirect.

## Timing
- Fetch to out_valid: 1 cycle. First instruction is valid after the first edge following reset release.
- Redirect sampled at edge E. imem_addr = redirect_pc after E. The target is pushed at E+1, with out_valid high after E+1. This gives a 1-cycle bubble.
- Steady state with out_ready held 1: one instruction per cycle, no bubbles.
- Backpressure: with out_ready low, fetch stops after 2 entries. imem_addr holds the next unfetched PC.
- halted rises on the edge that pushes the halt word.

## Configuration
- FETCH_STATS_EN defined: adds output ports fetch_count[15:0] and flush_count[15:0].
  - fetch_count increments per push.
  - flush_count increments per redirect that discards at least one queued entry.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - state type (RUN, HALT)
  - HALT_OPCODE default
  - queue DEPTH = 2
  - ADDR_W/DATA_W defaults
- Sub-module fetch_fifo: a 2-entry {pc, instr} queue with push, pop, flush and count. The top level holds the PC, the state machine, redirect/halt logic and the optional counters.

## Test plan
- Reset, imem word i = 32'h2000_0000|i, out_ready=1 -> out_pc 0,1,2,... with matching instructions, one per cycle, out_valid from the first post-reset edge.
- out_ready=0 for 5 cycles -> count stops at 2; imem_addr holds 2. Release -> pcs 0,1,2 delivered in order, none lost or duplicated.
- Redirect to 8'h40 while 2 entries are queued -> next delivered out_pc is 8'h40 after one bubble. With FETCH_STATS_EN, flush_count = 1.
- Run from 8'hFE -> out_pc sequence FE, FF, 00, 01. out_pc_next at FF is 00.
- Word at pc 5 has opcode 6'h3F -> it is delivered. halted=1, and no pc 6 is ever pushed. Redirect to 0 -> halted=0 and fetch resumes at 0.
- Redirect and pop in the same cycle at count 1 -> pop accepted, queue empty, next out_pc = target.
